yarp_dmem_responder: RTL and testbench
======================================

Name: yarp_dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store interface.
- Accepts one request at a time, tagged with a mem_encode access size (Byte_Access/Halfword_Access/Word_Access).
- Performs byte-lane steering, store strobing, load sign/zero extension, alignment and range checking against an internal word array.
- Returns a response after a programmable wait latency. It sits between the core's load/store unit and on-chip data RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- LATENCY, 1, extra wait cycles between accept and response; legal range 0..15.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4-aligned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  mem_encode access size.
- req_zero_ext  in  1  load zero-extends when 1 (LBU/LHU), sign-extends when 0.
- req_wdata  in  32  store data, right-justified (bits [7:0] for a byte store).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load data, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, Reserved size, or out-of-range access.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not reset.
- FSM state IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr/wr/size/zero_ext/wdata.
  - If LATENCY==0, go to RESP; otherwise load counter=LATENCY-1 and go to WAIT.
- FSM state WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP on the next edge.
- FSM state RESP:
  - rsp_valid=1, rsp_rdata and rsp_err stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid and req_ready are never both 1. Maximum throughput is one request per LATENCY+2 cycles.
- Latency: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Errors (rsp_err=1, rsp_rdata=0, no array write):
  - req_size==Reserved.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr-ADDR_BASE >= DEPTH_WORDS*4, computed as an unsigned 32-bit subtraction, so addresses below ADDR_BASE also fail.
- Word index: (addr-ADDR_BASE)[log2(DEPTH_WORDS)+1:2].
- Loads:
  - The word is read at the transition into RESP and registered.
  - Byte: lane addr[1:0] is selected.
  - Halfword: lane addr[1] is selected.
  - The result is extended to 32 bits per req_zero_ext.
- Stores:
  - The write is committed on the edge entering RESP.
  - Byte strobe: 1<<addr[1:0], with wdata[7:0] replicated on all lanes.
  - Halfword strobe: 4'b0011<<addr[1]*2, with wdata[15:0] replicated.
  - Word strobe: 4'b1111.
  - Unstrobed bytes are unchanged.
  - rsp_rdata=0.
- Reset mid-operation: return to IDLE with no response.
  - A store in WAIT is discarded.
  - A store whose commit edge coincides with reset is also discarded; reset has priority.
- Held response: if rsp_ready stays low, RESP holds indefinitely with outputs unchanged and the FSM accepts no new requests.
- Request inputs are sampled only at the accept edge; later changes are ignored.

Decomposition:
- Shared package yarp_pkg:
  - Reuse mem_encode.
  - Add typedef enum dmem_state_e {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}.
  - Add a function that returns the 4-bit store strobe from size and addr[1:0].
- Sub-module yarp_dmem_lane_align (combinational):
  - Inputs: size, addr[1:0], zero_ext, wdata, raw read word.
  - Outputs: strobe, replicated write data, extended load data, misalign flag.
  - The top level holds the FSM, counter, range check and array.

Test Plan:
- Reset, LATENCY=1: store Word 32'hDEAD_BEEF at addr 0x10, then load Word at 0x10 -> store response has rsp_err=0 and rsp_rdata=0; load returns 32'hDEAD_BEEF; rsp_valid rises 2 cycles after each accept.
- Byte-lane store and signed/unsigned load:
  - Word 0x20 = 0; store Byte 0x80 at 0x22; load Word 0x20 -> 32'h0080_0000.
  - Load Byte at 0x22 with zero_ext=0 -> 32'hFFFF_FF80; with zero_ext=1 -> 32'h0000_0080.
- Halfword: store Halfword 16'hA5C3 at 0x32 (Word 0x30 preset 32'h1111_1111) -> Word load returns 32'hA5C3_1111; signed Halfword load at 0x32 -> 32'hFFFF_A5C3.
- Errors with Word 0x40 preset 32'h1234_5678: Word store at 0x41, Halfword load at 0x43, Reserved size at 0x40, Word load at DEPTH_WORDS*4 -> each returns rsp_err=1, rsp_rdata=0; Word 0x40 still reads 32'h1234_5678.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata are stable and req_ready=0 throughout; the pending req_valid is accepted only in the cycle after the rsp_ready handshake.
- LATENCY=3, store 32'hCAFEF00D at 0x50 after Word 0x50 is preset to 0: assert reset one cycle after accept (in WAIT) -> no response and next-cycle outputs are at reset values; a subsequent load at 0x50 returns 0.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared definitions for the YARP data-memory path.
//   mem_encode   : access size carried with every load/store request
//   dmem_state_e : responder FSM states
//   dmem_strobe  : byte-enable mask for a store of a given size and offset
package yarp_pkg;

    typedef enum logic [1:0] {
        Byte_Access     = 2'b00,
        Halfword_Access = 2'b01,
        Reserved        = 2'b10,
        Word_Access     = 2'b11
    } mem_encode;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Reserved size yields an empty strobe, so nothing is ever written for it.
    function automatic logic [3:0] dmem_strobe(input mem_encode size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            Byte_Access:     strb = 4'b0001 << addr_lo;
            Halfword_Access: strb = 4'b0011 << {addr_lo[1], 1'b0};
            Word_Access:     strb = 4'b1111;
            default:         strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/yarp_dmem_lane_align.sv
// Byte-lane steering for the data-memory responder (purely combinational).
// Ports:
//   size      in  2   mem_encode access size
//   addr_lo   in  2   byte offset within the word
//   zero_ext  in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata     in  32  right-justified store data
//   rdata_raw in  32  word read from the array
//   strobe    out 4   byte enables for the store
//   wdata_rep out 32  store data replicated onto every lane
//   load_data out 32  selected lane, extended to 32 bits
//   misalign  out 1   halfword/word access not naturally aligned
module yarp_dmem_lane_align
    import yarp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        zero_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misalign
);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic zx);
        logic signed [31:0] s;
        s = 32'(signed'(b));
        return zx ? {24'h0, b} : s;
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic zx);
        logic signed [31:0] s;
        s = 32'(signed'(h));
        return zx ? {16'h0, h} : s;
    endfunction

    mem_encode   size_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign size_e   = mem_encode'(size);
    assign strobe   = dmem_strobe(size_e, addr_lo);
    assign byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata_raw[{addr_lo[1], 4'b0000} +: 16];
    assign misalign = ((size_e == Halfword_Access) && addr_lo[0]) ||
                      ((size_e == Word_Access) && (addr_lo != 2'b00));

    // Replicating the data lets the strobe alone pick the destination lane.
    always_comb begin
        case (size_e)
            Byte_Access:     wdata_rep = {4{wdata[7:0]}};
            Halfword_Access: wdata_rep = {2{wdata[15:0]}};
            default:         wdata_rep = wdata;
        endcase
    end

    always_comb begin
        case (size_e)
            Byte_Access:     load_data = extend_byte(byte_sel, zero_ext);
            Halfword_Access: load_data = extend_half(half_sel, zero_ext);
            Word_Access:     load_data = rdata_raw;
            default:         load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/yarp_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then presents a response held until rsp_ready.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_addr, req_wr, req_size request byte address, store flag, mem_encode size
//   req_zero_ext, req_wdata    load extension select, right-justified store data
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         extended load data (0 for stores/errors), error flag
module yarp_dmem_responder
    import yarp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_zero_ext,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dmem_state_e state;
    logic [3:0]  wait_cnt;

    // Request captured at the accept edge; data only, never reset.
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        zero_ext_q;

    logic        accept;
    logic        go_resp;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic        eff_wr;
    logic [1:0]  eff_size;
    logic        eff_zero_ext;
    logic [31:0] offset;
    logic        out_of_range;
    logic        reserved_size;
    logic        access_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0] raw_word;
    logic [3:0]  strobe;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        misalign;
    logic [31:0] rdata_next;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept  = req_ready && req_valid;
    assign go_resp = (accept && (LATENCY == 0)) ||
                     ((state == DMEM_WAIT) && (wait_cnt == 4'd0));

    // With zero latency the access happens on the accept edge itself, so the
    // live request inputs must be used instead of the captured copy.
    assign eff_addr     = (state == DMEM_IDLE) ? req_addr     : addr_q;
    assign eff_wdata    = (state == DMEM_IDLE) ? req_wdata    : wdata_q;
    assign eff_wr       = (state == DMEM_IDLE) ? req_wr       : wr_q;
    assign eff_size     = (state == DMEM_IDLE) ? req_size     : size_q;
    assign eff_zero_ext = (state == DMEM_IDLE) ? req_zero_ext : zero_ext_q;

    // Unsigned subtraction wraps addresses below ADDR_BASE to large offsets,
    // so one compare rejects both sides of the window.
    assign offset        = eff_addr - ADDR_BASE;
    assign out_of_range  = {1'b0, offset} >= SPAN;
    assign reserved_size = (mem_encode'(eff_size) == Reserved);
    assign access_err    = reserved_size || misalign || out_of_range;
    assign word_idx      = offset[IDX_W+1:2];
    assign raw_word      = mem[word_idx];
    assign rdata_next    = (access_err || eff_wr) ? 32'h0 : load_data;

    yarp_dmem_lane_align u_lane_align (
        .size      (eff_size),
        .addr_lo   (eff_addr[1:0]),
        .zero_ext  (eff_zero_ext),
        .wdata     (eff_wdata),
        .rdata_raw (raw_word),
        .strobe    (strobe),
        .wdata_rep (wdata_rep),
        .load_data (load_data),
        .misalign  (misalign)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wr_q       <= req_wr;
            size_q     <= req_size;
            zero_ext_q <= req_zero_ext;
        end
    end

    // Store commit on the edge entering RESP; a coincident reset wins.
    always_ff @(posedge clk) begin
        if (!reset && go_resp && eff_wr && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DMEM_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state     <= DMEM_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_next;
                            rsp_err   <= access_err;
                        end else begin
                            state    <= DMEM_WAIT;
                            wait_cnt <= CNT_INIT;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= DMEM_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_next;
                        rsp_err   <= access_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready) begin
                        state     <= DMEM_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= DMEM_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Bench for yarp_dmem_responder: a LATENCY=1 instance checked every cycle
// against a transaction-level model, plus a LATENCY=3 instance for the
// reset-during-wait scenario.
module tb_yarp_dmem_responder;
    import yarp_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          LAT   = 1;
    localparam int          LAT3  = 3;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_wr, req_zero_ext, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        reset3, req_valid3, req_wr3, req_zero_ext3, rsp_ready3;
    logic [31:0] req_addr3, req_wdata3;
    logic [1:0]  req_size3;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    yarp_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .ADDR_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size),
        .req_zero_ext(req_zero_ext), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    yarp_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT3), .ADDR_BASE(BASE)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr3), .req_wr(req_wr3), .req_size(req_size3),
        .req_zero_ext(req_zero_ext3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [DEPTH];

    function automatic void model_exec(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                                       input logic zx, input logic [31:0] wd,
                                       output logic err, output logic [31:0] rd);
        logic [31:0] off, w;
        int nbytes, lane, idx;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off    = a - BASE;
        lane   = int'(a[1:0]);
        err    = (sz == 2'b10) || ((lane % nbytes) != 0) || (off >= 32'(DEPTH * 4));
        rd     = 32'h0;
        if (err) return;
        idx = int'(off / 4);
        if (wr) begin
            for (int b = 0; b < nbytes; b++) mem_m[idx][8*(lane+b) +: 8] = wd[8*b +: 8];
        end else begin
            w = mem_m[idx] >> (8 * lane);
            if (nbytes == 1)      rd = zx ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            else if (nbytes == 2) rd = zx ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            else                  rd = w;
        end
    endfunction

    bit          model_on = 0;
    bit          m_busy = 0, m_rsp = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    int          m_wait = 0;
    logic [31:0] p_addr = 0, p_wd = 0;
    logic        p_wr = 0, p_zx = 0;
    logic [1:0]  p_sz = 0;

    // Compare current outputs, then advance the model by the coming edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            if (m_rsp) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (reset) begin
                m_busy = 0; m_rsp = 0; m_wait = 0; m_err = 0; m_rdata = 0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    p_addr = req_addr; p_wr = req_wr; p_sz = req_size;
                    p_zx = req_zero_ext; p_wd = req_wdata;
                    m_busy = 1; m_wait = LAT;
                    if (m_wait == 0) begin model_exec(p_addr, p_wr, p_sz, p_zx, p_wd, m_err, m_rdata); m_rsp = 1; end
                end
            end else if (!m_rsp) begin
                m_wait--;
                if (m_wait == 0) begin model_exec(p_addr, p_wr, p_sz, p_zx, p_wd, m_err, m_rdata); m_rsp = 1; end
            end else if (rsp_ready) begin
                m_busy = 0; m_rsp = 0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic txn(input logic [31:0] a, input logic wr, input logic [1:0] sz, input logic zx,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int lat;
        bit seen;
        rd = 32'h0; er = 1'b0;
        @(posedge clk); #1;
        req_valid = 1; req_addr = a; req_wr = wr; req_size = sz; req_zero_ext = zx; req_wdata = wd;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req_ready; end
        check("accept_in_time", 32'(seen), 32'd1);
        @(posedge clk); #1;
        // Scramble the request bus: the DUT must use its captured copy.
        req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wr = 1'($urandom);
        req_size = 2'($urandom); req_zero_ext = 1'($urandom);
        if (!seen) return;
        seen = 0; lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); lat++; seen = rsp_valid; end
        check("rsp_in_time", 32'(seen), 32'd1);
        if (seen) check("latency", lat, LAT + 1);
        rd = rsp_rdata; er = rsp_err;
    endtask

    task automatic txn3(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int lat;
        bit seen;
        rd = 32'h0; er = 1'b0;
        @(posedge clk); #1;
        req_valid3 = 1; req_addr3 = a; req_wr3 = wr; req_size3 = sz; req_zero_ext3 = 0; req_wdata3 = wd;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req_ready3; end
        check("l3_accept_in_time", 32'(seen), 32'd1);
        @(posedge clk); #1;
        req_valid3 = 0; req_addr3 = $urandom; req_wdata3 = $urandom;
        if (!seen) return;
        seen = 0; lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); lat++; seen = rsp_valid3; end
        check("l3_rsp_in_time", 32'(seen), 32'd1);
        if (seen) check("l3_latency", lat, LAT3 + 1);
        rd = rsp_rdata3; er = rsp_err3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          seen;
        int          sel;
        logic [31:0] a;

        reset = 1; req_valid = 0; req_addr = 0; req_wr = 0; req_size = 0;
        req_zero_ext = 0; req_wdata = 0; rsp_ready = 1;
        reset3 = 1; req_valid3 = 0; req_addr3 = 0; req_wr3 = 0; req_size3 = 0;
        req_zero_ext3 = 0; req_wdata3 = 0; rsp_ready3 = 1;

        @(posedge clk); #1;
        model_on = 1;
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        reset = 0; reset3 = 0;

        // Give every word a defined value so the model knows the whole array.
        for (int i = 0; i < DEPTH; i++) txn(BASE + 32'(i * 4), 1, Word_Access, 0, $urandom, rd, er);

        txn(32'h10, 1, Word_Access, 0, 32'hDEAD_BEEF, rd, er);
        check("st_word_rdata", rd, 32'h0);
        check("st_word_err", 32'(er), 32'd0);
        txn(32'h10, 0, Word_Access, 0, 32'h0, rd, er);
        check("ld_word", rd, 32'hDEAD_BEEF);

        txn(32'h20, 1, Word_Access, 0, 32'h0, rd, er);
        txn(32'h22, 1, Byte_Access, 0, 32'h0000_0080, rd, er);
        txn(32'h20, 0, Word_Access, 0, 32'h0, rd, er);
        check("byte_store_word", rd, 32'h0080_0000);
        txn(32'h22, 0, Byte_Access, 0, 32'h0, rd, er);
        check("lb_signed", rd, 32'hFFFF_FF80);
        txn(32'h22, 0, Byte_Access, 1, 32'h0, rd, er);
        check("lbu", rd, 32'h0000_0080);

        txn(32'h30, 1, Word_Access, 0, 32'h1111_1111, rd, er);
        txn(32'h32, 1, Halfword_Access, 0, 32'h0000_A5C3, rd, er);
        txn(32'h30, 0, Word_Access, 0, 32'h0, rd, er);
        check("half_store_word", rd, 32'hA5C3_1111);
        txn(32'h32, 0, Halfword_Access, 0, 32'h0, rd, er);
        check("lh_signed", rd, 32'hFFFF_A5C3);

        txn(32'h40, 1, Word_Access, 0, 32'h1234_5678, rd, er);
        txn(32'h41, 1, Word_Access, 0, 32'hFFFF_FFFF, rd, er);
        check("err_mis_word_flag", 32'(er), 32'd1);
        check("err_mis_word_rdata", rd, 32'h0);
        txn(32'h43, 0, Halfword_Access, 0, 32'h0, rd, er);
        check("err_mis_half_flag", 32'(er), 32'd1);
        check("err_mis_half_rdata", rd, 32'h0);
        txn(32'h40, 1, Reserved, 0, 32'hFFFF_FFFF, rd, er);
        check("err_reserved_flag", 32'(er), 32'd1);
        txn(32'(DEPTH * 4), 0, Word_Access, 0, 32'h0, rd, er);
        check("err_range_flag", 32'(er), 32'd1);
        check("err_range_rdata", rd, 32'h0);
        txn(32'h40, 0, Word_Access, 0, 32'h0, rd, er);
        check("err_no_write", rd, 32'h1234_5678);

        // Backpressure: response held 5 cycles while a second request waits.
        @(posedge clk); #1;
        rsp_ready = 0;
        req_valid = 1; req_addr = 32'h10; req_wr = 0; req_size = Word_Access; req_zero_ext = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = req_ready; end
        @(posedge clk); #1;
        req_addr = 32'h20;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
        check("bp_rsp_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1;
        @(negedge clk);
        check("bp_no_accept_during_hs", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_accept_after_hs", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = rsp_valid; end
        check("bp_second_rdata", rsp_rdata, 32'h0080_0000);

        // Randomised traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            else if (sel == 8) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
            else               a = $urandom;
            txn(a, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, rd, er);
        end

        // LATENCY=3: reset in WAIT discards the pending store.
        txn3(32'h50, 1, Word_Access, 32'h0, rd, er);
        check("l3_preset_err", 32'(er), 32'd0);
        @(posedge clk); #1;
        req_valid3 = 1; req_addr3 = 32'h50; req_wr3 = 1; req_size3 = Word_Access; req_wdata3 = 32'hCAFE_F00D;
        @(negedge clk);
        check("l3_ready_before_accept", 32'(req_ready3), 32'd1);
        @(posedge clk); #1;
        req_valid3 = 0; reset3 = 1;
        @(negedge clk);
        check("l3_waiting", 32'(req_ready3), 32'd0);
        @(posedge clk); #1;
        reset3 = 0;
        @(negedge clk);
        check("l3_rst_req_ready", 32'(req_ready3), 32'd1);
        check("l3_rst_rsp_valid", 32'(rsp_valid3), 32'd0);
        check("l3_rst_rsp_rdata", rsp_rdata3, 32'h0);
        check("l3_rst_rsp_err", 32'(rsp_err3), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid3) seen = 1; end
        check("l3_no_response", 32'(seen), 32'd0);
        txn3(32'h50, 0, Word_Access, 32'h0, rd, er);
        check("l3_store_discarded", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
